// File: rtl/mapreduce_pkg.sv
// Definitions shared by the MapReduce reduce and accumulate stages.
// The accumulator concatenates 32-bit reducer counters, so SUM_WIDTH lives here.
package mapreduce_pkg;

    localparam int SUM_WIDTH = 32;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } reducer_state_e;

    function automatic int table_depth(input int key_width);
        return 1 << key_width;
    endfunction

endpackage

// File: rtl/mapreduce_reducer.sv
// Reduce stage: sums (key, value) records into a per-key register table,
// counts accepted records, and drains the table over a valid/ready stream.
module mapreduce_reducer #(
    parameter int KEY_WIDTH      = 4,
    parameter int VALUE_WIDTH    = 16,
    parameter int SUM_WIDTH      = mapreduce_pkg::SUM_WIDTH,
    parameter bit CLEAR_ON_DRAIN = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_res,
    input  logic                   i_valid,
    input  logic [KEY_WIDTH-1:0]   i_key,
    input  logic [VALUE_WIDTH-1:0] i_value,
    output logic                   o_ready,
    input  logic                   i_rd_start,
    output logic                   o_rd_valid,
    output logic [KEY_WIDTH-1:0]   o_rd_key,
    output logic [SUM_WIDTH-1:0]   o_rd_sum,
    output logic                   o_rd_last,
    input  logic                   i_rd_ready,
    output logic [SUM_WIDTH-1:0]   o_reduce_counter
);

    import mapreduce_pkg::*;

    localparam int DEPTH = table_depth(KEY_WIDTH);
    localparam logic [KEY_WIDTH-1:0] LAST_KEY = '1;

    reducer_state_e                 state_reg, state_next;
    logic                           drain_pending_reg, drain_pending_next;
    logic [KEY_WIDTH-1:0]           index_reg, index_next;
    logic [SUM_WIDTH-1:0]           counter_reg, counter_next;
    logic [DEPTH-1:0][SUM_WIDTH-1:0] sum_reg;
    logic [DEPTH-1:0][SUM_WIDTH-1:0] sum_next;

    logic                 accept;
    logic                 drain_hs;
    logic [SUM_WIDTH-1:0] value_ext;

    // A drain request blocks intake in the same cycle so no record slips in
    // between the request and the first drained entry.
    assign o_ready = reset_n && (state_reg == RUN) && !i_res
                     && !drain_pending_reg && !i_rd_start;
    assign accept    = i_valid && o_ready;
    assign value_ext = SUM_WIDTH'(i_value);

    // Drain outputs come only from registers, never from i_rd_ready.
    assign o_rd_valid       = (state_reg == DRAIN);
    assign o_rd_key         = index_reg;
    assign o_rd_sum         = sum_reg[index_reg];
    assign o_rd_last        = o_rd_valid && (index_reg == LAST_KEY);
    assign drain_hs         = o_rd_valid && i_rd_ready;
    assign o_reduce_counter = counter_reg;

    always_comb begin
        state_next         = state_reg;
        drain_pending_next = drain_pending_reg;
        index_next         = index_reg;
        if (i_res) begin
            state_next         = RUN;
            drain_pending_next = 1'b0;
            index_next         = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (i_rd_start) begin
                        state_next         = DRAIN;
                        drain_pending_next = 1'b1;
                        index_next         = '0;
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        if (index_reg == LAST_KEY) begin
                            state_next         = RUN;
                            drain_pending_next = 1'b0;
                            index_next         = '0;
                        end else begin
                            index_next = index_reg + KEY_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_next         = RUN;
                    drain_pending_next = 1'b0;
                    index_next         = '0;
                end
            endcase
        end
    end

    always_comb begin
        counter_next = counter_reg;
        if (i_res) begin
            counter_next = '0;
        end else if (accept) begin
            counter_next = counter_reg + SUM_WIDTH'(1);
        end
    end

    // Accept and drain handshake never coincide: accept needs RUN, drain needs DRAIN.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [KEY_WIDTH-1:0] ENTRY_KEY = KEY_WIDTH'(gi);
            logic [SUM_WIDTH-1:0] entry_next;

            always_comb begin
                entry_next = sum_reg[gi];
                if (i_res) begin
                    entry_next = '0;
                end else if (accept && (i_key == ENTRY_KEY)) begin
                    entry_next = sum_reg[gi] + value_ext;
                end else if (CLEAR_ON_DRAIN && drain_hs && (index_reg == ENTRY_KEY)) begin
                    entry_next = '0;
                end
            end

            assign sum_next[gi] = entry_next;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= RUN;
            drain_pending_reg <= 1'b0;
            index_reg         <= '0;
            counter_reg       <= '0;
            sum_reg           <= '0;
        end else begin
            state_reg         <= state_next;
            drain_pending_reg <= drain_pending_next;
            index_reg         <= index_next;
            counter_reg       <= counter_next;
            sum_reg           <= sum_next;
        end
    end

endmodule
